// File: rtl/rgb_pwm_pkg.sv
// rgb_pwm_pkg: shared definitions for the RGB/LED PWM peripheral.
//   - Register offsets (word index = byte offset >> 2) for the 32-byte window.
//   - CTRL bit positions.
//   - duty_t: 8-bit duty cycle / PWM counter type.
//   - fade_step(): one linear fade step of an active duty toward its target.
package rgb_pwm_pkg;

  typedef logic [7:0] duty_t;

  localparam logic [2:0] OFF_CTRL    = 3'd0;
  localparam logic [2:0] OFF_TGT_R   = 3'd1;
  localparam logic [2:0] OFF_TGT_G   = 3'd2;
  localparam logic [2:0] OFF_TGT_B   = 3'd3;
  localparam logic [2:0] OFF_PERIODS = 3'd4;
  localparam logic [2:0] OFF_ACT     = 3'd5;

  localparam int CTRL_EN   = 0;
  localparam int CTRL_FADE = 1;
  localparam int CTRL_LED  = 2;

  // Move cur one step toward tgt, holding once they are equal.
  function automatic duty_t fade_step(input duty_t cur, input duty_t tgt);
    duty_t nxt;
    if (cur < tgt) begin
      nxt = cur + 8'd1;
    end else if (cur > tgt) begin
      nxt = cur - 8'd1;
    end else begin
      nxt = cur;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/pwm_channel.sv
// pwm_channel: one colour channel of the PWM peripheral.
//   Ports:
//     clk, reset      - system clock, asynchronous active-low reset
//     tgt             - buffered target duty written by software
//     fade            - 1: ACT steps +/-1 toward tgt per period, 0: ACT <- tgt
//     period_end      - one-cycle strobe at the last step of each PWM period
//     en              - channel output enable (CTRL.EN)
//     cnt             - shared 8-bit PWM counter
//     act             - active duty currently driving the compare
//     lit             - registered compare result (active-high)
module pwm_channel
  import rgb_pwm_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  duty_t tgt,
  input  logic  fade,
  input  logic  period_end,
  input  logic  en,
  input  duty_t cnt,
  output duty_t act,
  output logic  lit
);

  duty_t r_act;
  logic  r_lit;

  // Active duty: only reloaded at a period boundary so a period never tears.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_act <= 8'd0;
    end else if (period_end) begin
      r_act <= fade ? fade_step(r_act, tgt) : tgt;
    end else begin
      r_act <= r_act;
    end
  end

  // Compare register: ACT=255 still leaves cnt=255 dark, ACT=0 never lights.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_lit <= 1'b0;
    end else begin
      r_lit <= en && (cnt < r_act);
    end
  end

  assign act = r_act;
  assign lit = r_lit;

endmodule

// File: rtl/rgb_pwm_periph.sv
// rgb_pwm_periph: memory-mapped RGB/LED PWM peripheral on the dmem bus.
//   Parameters: BASE_ADDR (32-byte window base), PRESCALE (clk per PWM step),
//               ACTIVE_LOW (1: red/green/blue drive 0 when lit).
//   Ports:
//     clk, reset                  - system clock, asynchronous active-low reset
//     dmem_address/data_in/wren   - core data bus (full-word writes)
//     rd_data                     - read data, registered one cycle after address
//     led                         - CTRL.LED (active-high)
//     red, green, blue            - PWM outputs
module rgb_pwm_periph
  import rgb_pwm_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_1000,
  parameter int          PRESCALE   = 47,
  parameter bit          ACTIVE_LOW = 1'b1
)
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] dmem_address,
  input  logic [31:0] dmem_data_in,
  input  logic        dmem_wren,
  output logic [31:0] rd_data,
  output logic        led,
  output logic        red,
  output logic        green,
  output logic        blue
);

  localparam int             PRE_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRESCALE - 1);

  logic [2:0]       r_ctrl;
  duty_t            r_tgt_r, r_tgt_g, r_tgt_b;
  logic [PRE_W-1:0] r_pre;
  duty_t            r_cnt;
  logic [15:0]      r_periods;
  logic [31:0]      r_rd_data;

  logic             w_hit, w_wr, w_en_next, w_tick, w_period_end;
  logic [2:0]       w_off;
  logic [31:0]      w_rd_next;
  duty_t            w_act_r, w_act_g, w_act_b;
  logic             w_lit_r, w_lit_g, w_lit_b;
  logic             w_unused;

  assign w_hit        = (dmem_address[31:5] == BASE_ADDR[31:5]);
  assign w_off        = dmem_address[4:2];
  assign w_wr         = dmem_wren && w_hit;
  assign w_tick       = r_ctrl[CTRL_EN] && (r_pre == PRE_MAX);
  assign w_period_end = w_tick && (r_cnt == 8'hFF);
  assign w_unused     = &{1'b0, dmem_address[1:0], dmem_data_in[31:8]};

  // EN as it will be after this edge; a write clearing EN stops counting at once.
  always_comb begin
    w_en_next = r_ctrl[CTRL_EN];
    if (w_wr && (w_off == OFF_CTRL)) begin
      w_en_next = dmem_data_in[CTRL_EN];
    end else begin
      w_en_next = r_ctrl[CTRL_EN];
    end
  end

  // Software-writable registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ctrl  <= 3'd0;
      r_tgt_r <= 8'd0;
      r_tgt_g <= 8'd0;
      r_tgt_b <= 8'd0;
    end else if (w_wr) begin
      case (w_off)
        OFF_CTRL:  r_ctrl  <= dmem_data_in[2:0];
        OFF_TGT_R: r_tgt_r <= dmem_data_in[7:0];
        OFF_TGT_G: r_tgt_g <= dmem_data_in[7:0];
        OFF_TGT_B: r_tgt_b <= dmem_data_in[7:0];
        default:   r_ctrl  <= r_ctrl;
      endcase
    end
  end

  // Prescaler, PWM counter and period count; all pinned to 0 while disabled.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pre     <= {PRE_W{1'b0}};
      r_cnt     <= 8'd0;
      r_periods <= 16'd0;
    end else if (!r_ctrl[CTRL_EN] || !w_en_next) begin
      r_pre     <= {PRE_W{1'b0}};
      r_cnt     <= 8'd0;
      r_periods <= 16'd0;
    end else if (w_tick) begin
      r_pre <= {PRE_W{1'b0}};
      r_cnt <= r_cnt + 8'd1;
      if (w_period_end) begin
        r_periods <= r_periods + 16'd1;
      end
    end else begin
      r_pre <= r_pre + PRE_W'(1);
    end
  end

  // Read mux for the address presented this cycle.
  always_comb begin
    w_rd_next = 32'd0;
    if (w_hit) begin
      case (w_off)
        OFF_CTRL:    w_rd_next = {29'd0, r_ctrl};
        OFF_TGT_R:   w_rd_next = {24'd0, r_tgt_r};
        OFF_TGT_G:   w_rd_next = {24'd0, r_tgt_g};
        OFF_TGT_B:   w_rd_next = {24'd0, r_tgt_b};
        OFF_PERIODS: w_rd_next = {16'd0, r_periods};
        OFF_ACT:     w_rd_next = {8'd0, w_act_b, w_act_g, w_act_r};
        default:     w_rd_next = 32'd0;
      endcase
    end else begin
      w_rd_next = 32'd0;
    end
  end

  // Read data register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rd_data <= 32'd0;
    end else begin
      r_rd_data <= w_rd_next;
    end
  end

  pwm_channel u_ch_r (
    .clk(clk), .reset(reset), .tgt(r_tgt_r), .fade(r_ctrl[CTRL_FADE]),
    .period_end(w_period_end), .en(r_ctrl[CTRL_EN]), .cnt(r_cnt),
    .act(w_act_r), .lit(w_lit_r)
  );

  pwm_channel u_ch_g (
    .clk(clk), .reset(reset), .tgt(r_tgt_g), .fade(r_ctrl[CTRL_FADE]),
    .period_end(w_period_end), .en(r_ctrl[CTRL_EN]), .cnt(r_cnt),
    .act(w_act_g), .lit(w_lit_g)
  );

  pwm_channel u_ch_b (
    .clk(clk), .reset(reset), .tgt(r_tgt_b), .fade(r_ctrl[CTRL_FADE]),
    .period_end(w_period_end), .en(r_ctrl[CTRL_EN]), .cnt(r_cnt),
    .act(w_act_b), .lit(w_lit_b)
  );

  assign rd_data = r_rd_data;
  assign led     = r_ctrl[CTRL_LED];
  // Polarity flip of a registered compare; reset leaves them inactive.
  assign red     = w_lit_r ^ ACTIVE_LOW;
  assign green   = w_lit_g ^ ACTIVE_LOW;
  assign blue    = w_lit_b ^ ACTIVE_LOW;

endmodule

// File: tb/tb_rgb_pwm_periph.sv
// tb_rgb_pwm_periph: self-checking bench for rgb_pwm_periph (PRESCALE=2,
// ACTIVE_LOW=1). A time-based reference model (cycles since counting began)
// predicts every output each cycle; directed steps add hand-derived checks.
module tb_rgb_pwm_periph;

  localparam int          P    = 2;
  localparam int          PER  = P * 256;
  localparam logic [31:0] BASE = 32'h0000_1000;

  logic        clk;
  logic        reset;
  logic [31:0] dmem_address;
  logic [31:0] dmem_data_in;
  logic        dmem_wren;
  logic [31:0] rd_data;
  logic        led, red, green, blue;

  rgb_pwm_periph #(.BASE_ADDR(BASE), .PRESCALE(P), .ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .reset(reset), .dmem_address(dmem_address),
    .dmem_data_in(dmem_data_in), .dmem_wren(dmem_wren), .rd_data(rd_data),
    .led(led), .red(red), .green(green), .blue(blue)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state (values before the next clock edge).
  bit          m_en, m_fade, m_led, m_pe;
  int          m_tgt [3];
  int          m_act [3];
  int          m_periods;
  int          m_t;
  bit          m_lit [3];
  logic [31:0] m_rd;

  function automatic void model_reset();
    m_en = 0; m_fade = 0; m_led = 0; m_pe = 0;
    m_periods = 0; m_t = 0; m_rd = 32'd0;
    for (int c = 0; c < 3; c++) begin
      m_tgt[c] = 0; m_act[c] = 0; m_lit[c] = 0;
    end
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    logic [31:0] v;
    v = 32'd0;
    if (a[31:5] == BASE[31:5]) begin
      case (a[4:2])
        3'd0: v = {29'd0, m_led, m_fade, m_en};
        3'd1: v = 32'(m_tgt[0]);
        3'd2: v = 32'(m_tgt[1]);
        3'd3: v = 32'(m_tgt[2]);
        3'd4: v = 32'(m_periods);
        3'd5: v = {8'd0, 8'(m_act[2]), 8'(m_act[1]), 8'(m_act[0])};
        default: v = 32'd0;
      endcase
    end
    return v;
  endfunction

  // Advance the model across one rising edge using the inputs present at it.
  function automatic void model_edge();
    bit new_en;
    int cnt;
    if (!reset) begin
      model_reset();
      return;
    end
    m_rd = model_read(dmem_address);
    cnt  = (m_t / P) % 256;
    for (int c = 0; c < 3; c++) m_lit[c] = m_en && (cnt < m_act[c]);
    m_pe = m_en && ((m_t % PER) == PER - 1);
    if (m_pe) begin
      m_periods = (m_periods + 1) % 65536;
      for (int c = 0; c < 3; c++) begin
        if (!m_fade) m_act[c] = m_tgt[c];
        else if (m_act[c] < m_tgt[c]) m_act[c] = m_act[c] + 1;
        else if (m_act[c] > m_tgt[c]) m_act[c] = m_act[c] - 1;
      end
    end
    new_en = m_en;
    if (dmem_wren && (dmem_address[31:5] == BASE[31:5])) begin
      case (dmem_address[4:2])
        3'd0: begin
          new_en = dmem_data_in[0]; m_fade = dmem_data_in[1]; m_led = dmem_data_in[2];
        end
        3'd1: m_tgt[0] = int'(dmem_data_in[7:0]);
        3'd2: m_tgt[1] = int'(dmem_data_in[7:0]);
        3'd3: m_tgt[2] = int'(dmem_data_in[7:0]);
        default: ;
      endcase
    end
    if (!m_en || !new_en) begin
      m_t = 0;
      m_periods = 0;
    end else begin
      m_t = m_t + 1;
    end
    m_en = new_en;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("outputs", {28'd0, rd_data, led, red, green, blue},
        {28'd0, m_rd, m_led, !m_lit[0], !m_lit[1], !m_lit[2]});
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    dmem_address = a; dmem_data_in = d; dmem_wren = 1'b1;
    cyc();
    dmem_wren = 1'b0; dmem_address = 32'd0; dmem_data_in = 32'd0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] v);
    dmem_address = a; dmem_wren = 1'b0;
    cyc();
    v = rd_data;
    dmem_address = 32'd0;
  endtask

  task automatic run_to_pe();
    int n;
    n = 0;
    do begin
      cyc();
      n++;
    end while (!m_pe && n < PER + 4);
    chk("period_end_reached", {63'd0, m_pe}, 64'd1);
  endtask

  task automatic run_to_pre_pe();
    int n;
    n = 0;
    while (!(m_en && ((m_t % PER) == PER - 1)) && n < PER + 4) begin
      cyc();
      n++;
    end
    chk("pre_period_end_reached", {63'd0, (m_en && ((m_t % PER) == PER - 1))}, 64'd1);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog expired before the directed sequence finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] v;
    logic [31:0] d;
    int          n_a, n_b, r;
    int          fade_exp [4];
    fade_exp = '{1, 2, 3, 3};

    reset = 1'b0; dmem_address = 32'd0; dmem_data_in = 32'd0; dmem_wren = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("reset_state", {28'd0, rd_data, led, red, green, blue}, {28'd0, 32'd0, 4'b0111});
    reset = 1'b1;
    cyc();

    // Basic duty: 64/256 with PRESCALE=2 -> 128 lit cycles per 512.
    wr(BASE + 32'h4, 32'd64);
    wr(BASE, 32'd1);
    repeat (PER) cyc();
    n_a = 0;
    for (int i = 0; i < PER; i++) begin
      cyc();
      if (red == 1'b0) n_a++;
    end
    chk("red_lit_cycles", 64'(n_a), 64'd128);
    rd(BASE + 32'h14, v);
    chk("act_after_duty", 64'(v), 64'h0000_0040);

    // Double buffer: mid-period write held until the boundary.
    wr(BASE + 32'h8, 32'd200);
    rd(BASE + 32'h14, v);
    chk("act_g_held", 64'(v), 64'h0000_0040);
    run_to_pe();
    rd(BASE + 32'h14, v);
    chk("act_g_updated", 64'(v), 64'h0000_C840);
    // Write landing exactly on the period-end edge applies one boundary later.
    run_to_pre_pe();
    wr(BASE + 32'h8, 32'd10);
    rd(BASE + 32'h14, v);
    chk("act_g_boundary_write", 64'(v), 64'h0000_C840);
    run_to_pe();
    rd(BASE + 32'h14, v);
    chk("act_g_next_boundary", 64'(v), 64'h0000_0A40);

    // Fade: ACT_B ramps 0 -> 3 one step per period.
    wr(BASE + 32'hC, 32'd3);
    wr(BASE, 32'd0);
    wr(BASE, 32'd3);
    for (int i = 0; i < 4; i++) begin
      run_to_pe();
      rd(BASE + 32'h14, v);
      chk("fade_step", 64'(v), 64'({8'd0, 8'(fade_exp[i]), 8'd10, 8'd64}));
    end

    // Edge duties: 0 never lit, 255 dark for exactly PRESCALE cycles.
    wr(BASE + 32'h4, 32'd0);
    wr(BASE + 32'h8, 32'd255);
    wr(BASE, 32'd1);
    run_to_pe();
    n_a = 0; n_b = 0;
    for (int i = 0; i < PER; i++) begin
      cyc();
      if (red == 1'b0) n_a++;
      if (green == 1'b1) n_b++;
    end
    chk("duty0_lit_cycles", 64'(n_a), 64'd0);
    chk("duty255_dark_cycles", 64'(n_b), 64'(P));

    // Bus decode.
    wr(32'h0000_1018, 32'hFFFF_FFFF);
    wr(32'h0000_2000, 32'hFFFF_FFFF);
    rd(32'h0000_1018, v);
    chk("rd_unmapped", 64'(v), 64'd0);
    rd(32'h0000_2000, v);
    chk("rd_miss", 64'(v), 64'd0);
    rd(BASE + 32'h3, v);
    chk("rd_ctrl_lowbits_ignored", 64'(v), 64'd1);
    wr(BASE, 32'd4);
    chk("led_on", {63'd0, led}, 64'd1);
    cyc();
    chk("led_only_colours_off", {60'd0, led, red, green, blue}, 64'hF);
    wr(BASE, 32'd1);
    repeat (3 * PER) cyc();
    rd(BASE + 32'h10, v);
    chk("periods_after_3", 64'(v), 64'd3);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      d = $urandom;
      if (r < 3) begin
        d = d & 32'h7;
        if ($urandom_range(0, 3) != 0) d[0] = 1'b1;
        wr(BASE, d);
      end else if (r < 12) begin
        wr(BASE + 32'(4 * $urandom_range(1, 3)), d);
      end else if (r < 16) begin
        wr(($urandom_range(0, 1) == 0) ? (BASE + 32'(4 * $urandom_range(4, 7)))
                                       : (32'h0000_3000 + 32'(4 * $urandom_range(0, 7))), d);
      end else if (r < 40) begin
        rd(BASE + 32'($urandom_range(0, 31)), v);
      end else begin
        cyc();
      end
    end

    // Asynchronous reset in the middle of a run.
    wr(BASE, 32'd5);
    wr(BASE + 32'h4, 32'd128);
    repeat (PER + 20) cyc();
    #2 reset = 1'b0;
    #1;
    chk("async_reset_outputs", {60'd0, led, red, green, blue}, 64'h7);
    chk("async_reset_rd_data", 64'(rd_data), 64'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    rd(BASE, v);
    chk("ctrl_after_reset", 64'(v), 64'd0);
    rd(BASE + 32'h14, v);
    chk("act_after_reset", 64'(v), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
